// File: rtl/uart_rx_byte.sv
// UART receiver: 8N1, LSB first, mid-bit sampling.
// Received bytes land in a one-entry holding register drained by rd.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   logic          rx_m;
   logic          rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         shreg     <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (rd && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_M1) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_M1) begin
                  // Back to IDLE at mid-stop so a following start edge is caught
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  if (rx_s) begin
                     data    <= shreg;
                     valid   <= 1'b1;
                     overrun <= (overrun || valid) && !rd;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
